// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and a
// per-grant hold limit that force-releases a requester after MAX_HOLD cycles.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0] state;
    logic [2:0] ptr;
    logic [7:0] hcnt;
    logic [2:0] win;
    logic [2:0] cand;
    logic       found;

    // Search starts just past the last winner so it is considered last.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            cand = ptr + 3'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hcnt      <= '0;
            ptr       <= 3'd7;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= GRANT;
                        gnt       <= 8'b1 << win;
                        gnt_idx   <= win;
                        gnt_valid <= 1'b1;
                        ptr       <= win;
                        hcnt      <= 8'd1;
                    end else begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!req[gnt_idx]) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                    end else if (hcnt == 8'(MAX_HOLD)) begin
                        state     <= IDLE;
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        timeout   <= 1'b1;
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed testbench for rr_arbiter8 with MAX_HOLD=4; expected grants are
// hand-derived from the round-robin pointer sequence.
module tb_rr_arbiter8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int unsigned checks;
    int unsigned errors;

    rr_arbiter8 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_grant(input string tag, input logic [2:0] idx);
        logic [7:0] onehot;
        onehot = 8'b1 << idx;
        check({tag, " gnt"}, gnt, onehot);
        check({tag, " idx"}, {5'b0, gnt_idx}, {5'b0, idx});
        check({tag, " valid"}, {7'b0, gnt_valid}, 8'h01);
        check({tag, " timeout"}, {7'b0, timeout}, 8'h00);
    endtask

    task automatic check_idle(input string tag, input logic to_exp);
        check({tag, " gnt"}, gnt, 8'h00);
        check({tag, " valid"}, {7'b0, gnt_valid}, 8'h00);
        check({tag, " timeout"}, {7'b0, timeout}, {7'b0, to_exp});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req = 8'h00;
        tick();
        tick();
        check_idle("reset", 1'b0);
        check("reset idx", {5'b0, gnt_idx}, 8'h00);
        rst = 1'b0;

        // Basic: 0 then 7
        req = 8'h81;
        tick();
        check_grant("basic0", 3'd0);
        req = 8'h80;
        tick();
        check_idle("basic gap", 1'b0);
        tick();
        check_grant("basic7", 3'd7);
        req = 8'h00;
        tick();
        check_idle("basic end", 1'b0);
        check("basic idx held", {5'b0, gnt_idx}, 8'h07);

        // Full rotation with wrap; ptr=7 so 0 goes first
        req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            check_grant($sformatf("rot%0d c1", k), 3'(k % 8));
            tick();
            check_grant($sformatf("rot%0d c2", k), 3'(k % 8));
            req = 8'hFF & ~(8'b1 << (k % 8));
            tick();
            check_idle($sformatf("rot%0d gap", k), 1'b0);
            req = 8'hFF;
            tick();
        end
        check_grant("rot final", 3'd1);
        req = 8'h00;
        tick();
        check_idle("rot end", 1'b0);

        // Starvation avoidance: ptr=1, so 2 wins, times out, then 3
        req = 8'h0C;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_grant($sformatf("starve hold%0d", i), 3'd2);
            tick();
        end
        check_idle("starve timeout", 1'b1);
        tick();
        check_grant("starve next", 3'd3);
        req = 8'h00;
        tick();
        check_idle("starve end", 1'b0);

        // Single requester timeout and re-grant
        req = 8'h04;
        tick();
        for (int i = 0; i < 4; i++) begin
            check_grant($sformatf("single hold%0d", i), 3'd2);
            tick();
        end
        check_idle("single timeout", 1'b1);
        tick();
        check_grant("single regrant", 3'd2);
        req = 8'h00;
        tick();
        check_idle("single end", 1'b0);

        // Release coinciding with hcnt == MAX_HOLD is a normal release
        req = 8'h04;
        tick();
        tick();
        tick();
        tick();
        check_grant("coincide c4", 3'd2);
        req = 8'h00;
        tick();
        check_idle("coincide release", 1'b0);

        // Asynchronous reset mid-grant
        req = 8'h10;
        tick();
        check_grant("arst pre", 3'd4);
        #2;
        rst = 1'b1;
        #1;
        check_idle("arst async", 1'b0);
        check("arst idx", {5'b0, gnt_idx}, 8'h00);
        tick();
        rst = 1'b0;
        req = 8'h30;
        tick();
        check_grant("arst post", 3'd4);
        req = 8'h00;
        tick();
        check_idle("arst end", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
